key_event_ctrl: RTL and testbench
=================================

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk cycles per scan_tick pulse, legal range 2..2^20.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: event queue entries, a power of two, 2..16.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port btn, input, 16: debounced key levels, index = row*4+col, 1 = pressed.
REQ-006 SHALL have port clr, input, 1: synchronous flush of queue, pending events and ovf.
REQ-007 SHALL have port scan_tick, output, 1: one-cycle enable pulse for the keypad row scanner.
REQ-008 SHALL have port ev_valid, output, 1: queue head holds an event.
REQ-009 SHALL have port ev_ready, input, 1: consumer accepts the head; a pop occurs when ev_valid and ev_ready are both 1.
REQ-010 SHALL have port ev_code, output, 4: key index of the head event.
REQ-011 SHALL have port ev_rel, output, 1: head event type, 0 = press, 1 = release.
REQ-012 SHALL have port ovf, output, 1: sticky flag set when an event is lost.
REQ-013 SHALL have port any_key, output, 1: OR of the registered btn.

Function
REQ-014 SHALL count clk cycles 0..SCAN_DIV-1 and pulse scan_tick for one cycle when the count equals SCAN_DIV-1, then wrap to 0.
REQ-015 SHALL register btn into btn_q every cycle, and register btn_q into btn_p every cycle.
REQ-016 SHALL treat bit i as a press edge when btn_q[i]=1 and btn_p[i]=0, and as a release edge when btn_q[i]=0 and btn_p[i]=1.
REQ-017 SHALL hold two 16-bit pending vectors, press_pend and rel_pend, and set the matching bit on each edge.
REQ-018 SHALL, when a new edge hits a pending bit of the same type that is not being granted that cycle, keep the bit set and set ovf.
REQ-019 SHALL grant at most one pending event per cycle, and only when the queue is not full or a pop occurs in that same cycle.
REQ-020 SHALL grant by fixed priority: lowest-index press_pend bit first; rel_pend bits (lowest index first) only when press_pend is all zero.
REQ-021 SHALL, on a grant, clear the granted pending bit and write {type, index} to the queue tail.
REQ-022 SHALL retain pending bits while the queue is full; events are delayed, not dropped.
REQ-023 SHALL make the queue first-word-fall-through: ev_valid, ev_code and ev_rel reflect the head combinationally from registered state.
REQ-024 SHALL, with an idle queue and no other pending events, raise ev_valid after edge k+2, where edge k is the edge on which btn_q first captures the change.
REQ-025 SHALL allow a simultaneous push and pop when full; occupancy stays FIFO_DEPTH.
REQ-026 SHALL, when a press and a release of the same key are both pending, emit the press first.
REQ-027 SHALL, on clr=1, empty the queue, zero both pending vectors and ovf, and ignore edges and grants in that cycle; btn_q and btn_p keep updating.
REQ-028 SHALL NOT let clr reset the scan_tick counter.
REQ-029 SHALL NOT let ovf be cleared by a pop.

Reset
REQ-030 SHALL, while rst_n=0, force to zero: btn_q, btn_p, both pending vectors, queue pointers and count, the scan counter, and ovf.
REQ-031 SHALL, during reset, drive scan_tick=0, ev_valid=0, ev_code=0, ev_rel=0, any_key=0.
REQ-032 SHALL generate press events after reset release for keys held through reset, because btn_p resets to 0.
REQ-033 SHALL abandon any in-flight grant when reset asserts mid-operation; no event survives reset.

Structure
REQ-034 SHALL keep the event encoding (type bit position, 5-bit event width) and default parameter values in a shared package key_pkg.
REQ-035 SHALL implement the queue as sub-module key_evt_fifo (push/pop, full/empty, FWFT); arbitration and edge logic stay in the top module.

Verification
REQ-036 SHALL test single press: btn=16'h0020 from idle -> one event {rel=0, code=5}, ev_valid high 2 cycles after btn_q sample; release -> {1, 5}.
REQ-037 SHALL test simultaneous presses: btn 0 -> 16'h8101 in one cycle -> events in order codes 0, 8, 15, on three consecutive cycles with ev_ready=1.
REQ-038 SHALL test back-pressure: ev_ready=0, FIFO_DEPTH=4, press keys 0..5 together -> 4 queued, 2 pending; ovf=0; raising ev_ready drains all 6 in index order.
REQ-039 SHALL test lost event: queue full, key 3 press pending, key 3 released then re-pressed -> ovf=1, and exactly one press for key 3 is emitted.
REQ-040 SHALL test clr and reset: clr with 3 queued -> ev_valid=0 next cycle, ovf=0, no re-emission for held keys; rst_n low with key 9 held -> after release, one {0, 9} event.
REQ-041 SHALL test scan tick: SCAN_DIV=4 -> scan_tick high every 4th cycle, period unaffected by clr.

Source files
------------

// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module  : key_pkg
// Purpose : Shared event encoding and defaults for the keypad event path.
// Rev     : 1.0
// ============================================================================
package key_pkg;

  localparam int SCAN_DIV_DEF   = 50000;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int EVT_W          = 5;
  localparam int EVT_REL_BIT    = 4;

  typedef enum logic {
    EV_PRESS   = 1'b0,
    EV_RELEASE = 1'b1
  } ev_type_e;

  typedef struct packed {
    ev_type_e   rel;
    logic [3:0] code;
  } key_evt_t;

  // Returns {found, index-of-lowest-set-bit}.
  function automatic logic [4:0] first_set(input logic [15:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module  : key_evt_fifo
// Purpose : First-word-fall-through event queue with flush.
// Rev     : 1.0
// ============================================================================
module key_evt_fifo
  import key_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [EVT_W-1:0] i_wdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [EVT_W-1:0] o_rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [EVT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  // Head is masked so the data outputs read zero whenever nothing is queued.
  assign o_rdata = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clr) r_mem[r_wr] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : key_event_ctrl
// Purpose : Keypad edge detection, pending-event arbitration and scan timing.
// Rev     : 1.0
// ============================================================================
module key_event_ctrl
  import key_pkg::*;
#(
  parameter int SCAN_DIV   = SCAN_DIV_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] btn,
  input  logic        clr,
  output logic        scan_tick,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [3:0]  ev_code,
  output logic        ev_rel,
  output logic        ovf,
  output logic        any_key
);

  localparam int              CNT_W       = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] c_scan_last = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] r_scan_cnt;
  logic [15:0]      r_btn_q, r_btn_p;
  logic [15:0]      r_press_pend, r_rel_pend;
  logic             r_ovf;

  logic [15:0]      w_press_edge, w_rel_edge;
  logic [4:0]       w_press_first, w_rel_first;
  logic             w_full, w_empty, w_pop, w_gnt_ok;
  logic             w_gnt, w_gnt_rel;
  logic [3:0]       w_gnt_idx;
  logic [15:0]      w_press_kept, w_rel_kept;
  logic             w_lost;
  key_evt_t         w_wevt, w_head;
  logic [EVT_W-1:0] w_rdata;

  assign scan_tick = (r_scan_cnt == c_scan_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_scan_cnt <= '0;
    else if (scan_tick) r_scan_cnt <= '0;
    else                r_scan_cnt <= r_scan_cnt + 1'b1;
  end

  assign w_press_edge  = r_btn_q & ~r_btn_p;
  assign w_rel_edge    = ~r_btn_q & r_btn_p;
  assign w_press_first = first_set(r_press_pend);
  assign w_rel_first   = first_set(r_rel_pend);
  assign w_pop         = ev_valid & ev_ready;
  assign w_gnt_ok      = (~w_full | w_pop) & ~clr;

  // Presses always win over releases so a key's press precedes its release.
  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_rel = 1'b0;
    w_gnt_idx = '0;
    if (w_gnt_ok) begin
      if (w_press_first[4]) begin
        w_gnt     = 1'b1;
        w_gnt_idx = w_press_first[3:0];
      end else if (w_rel_first[4]) begin
        w_gnt     = 1'b1;
        w_gnt_rel = 1'b1;
        w_gnt_idx = w_rel_first[3:0];
      end
    end
  end

  assign w_press_kept = r_press_pend & ~((w_gnt && !w_gnt_rel) ? (16'd1 << w_gnt_idx) : 16'd0);
  assign w_rel_kept   = r_rel_pend   & ~((w_gnt &&  w_gnt_rel) ? (16'd1 << w_gnt_idx) : 16'd0);
  assign w_lost       = |(w_press_edge & w_press_kept) | |(w_rel_edge & w_rel_kept);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_q      <= '0;
      r_btn_p      <= '0;
      r_press_pend <= '0;
      r_rel_pend   <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_btn_q <= btn;
      r_btn_p <= r_btn_q;
      if (clr) begin
        r_press_pend <= '0;
        r_rel_pend   <= '0;
        r_ovf        <= 1'b0;
      end else begin
        r_press_pend <= w_press_kept | w_press_edge;
        r_rel_pend   <= w_rel_kept | w_rel_edge;
        r_ovf        <= r_ovf | w_lost;
      end
    end
  end

  assign w_wevt.rel  = w_gnt_rel ? EV_RELEASE : EV_PRESS;
  assign w_wevt.code = w_gnt_idx;

  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (clr),
    .i_push  (w_gnt),
    .i_pop   (w_pop),
    .i_wdata (w_wevt),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_rdata (w_rdata)
  );

  assign w_head   = key_evt_t'(w_rdata);
  assign ev_valid = ~w_empty;
  assign ev_code  = w_head.code;
  assign ev_rel   = w_rdata[EVT_REL_BIT];
  assign ovf      = r_ovf;
  assign any_key  = |r_btn_q;

endmodule
`default_nettype wire

// File: tb/tb_key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_key_event_ctrl
// Purpose : Scoreboard bench with a queue-based reference model of the event path.
// Rev     : 1.0
// ============================================================================
module tb_key_event_ctrl;
  import key_pkg::*;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] btn = '0;
  logic        clr = 1'b0;
  logic        ev_ready = 1'b1;
  logic        scan_tick, ev_valid, ev_rel, ovf, any_key;
  logic [3:0]  ev_code;

  key_event_ctrl #(.SCAN_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .clr       (clr),
    .scan_tick (scan_tick),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_code   (ev_code),
    .ev_rel    (ev_rel),
    .ovf       (ovf),
    .any_key   (any_key)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: key levels, pending sets and the expected-event queue.
  bit         mq[16], mp[16], pp[16], rp[16];
  bit         movf;
  int         cyc;
  logic [4:0] mfifo[$];
  logic [4:0] log_ev[$];
  int         log_cyc[$];
  int         gcyc = 0;

  always @(posedge clk) gcyc <= gcyc + 1;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mq[i] = 0; mp[i] = 0; pp[i] = 0; rp[i] = 0;
    end
    movf = 0;
    cyc  = 0;
    mfifo.delete();
  endtask

  task automatic model_step();
    bit pop, grel;
    int gi;
    pop = (mfifo.size() > 0) && ev_ready;
    if (clr) begin
      mfifo.delete();
      for (int i = 0; i < 16; i++) begin pp[i] = 0; rp[i] = 0; end
      movf = 0;
    end else begin
      gi = -1;
      grel = 0;
      if (mfifo.size() < DEPTH || pop) begin
        for (int i = 0; i < 16; i++) if (pp[i] && gi < 0) gi = i;
        if (gi < 0)
          for (int i = 0; i < 16; i++) if (rp[i] && gi < 0) begin gi = i; grel = 1; end
      end
      if (pop) void'(mfifo.pop_front());
      if (gi >= 0) begin
        if (grel) rp[gi] = 0; else pp[gi] = 0;
        mfifo.push_back({grel, 4'(gi)});
      end
      for (int i = 0; i < 16; i++) begin
        if (mq[i] && !mp[i]) begin if (pp[i]) movf = 1; pp[i] = 1; end
        if (!mq[i] && mp[i]) begin if (rp[i]) movf = 1; rp[i] = 1; end
      end
    end
    for (int i = 0; i < 16; i++) begin
      mp[i] = mq[i];
      mq[i] = btn[i];
    end
    cyc++;
  endtask

  function automatic bit model_any();
    bit a;
    a = 0;
    for (int i = 0; i < 16; i++) a |= mq[i];
    return a;
  endfunction

  initial begin : model
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_ev_code", ev_code, 0);
        chk("rst_ev_rel", ev_rel, 0);
        chk("rst_scan_tick", scan_tick, 0);
        chk("rst_any_key", any_key, 0);
        chk("rst_ovf", ovf, 0);
      end else begin
        chk("ev_valid", ev_valid, mfifo.size() > 0);
        if (ev_valid && mfifo.size() > 0) chk("ev_head", {ev_rel, ev_code}, mfifo[0]);
        chk("ovf", ovf, movf);
        chk("any_key", any_key, model_any());
        chk("scan_tick", scan_tick, (cyc % DIV) == DIV - 1);
        if (ev_valid && ev_ready) begin
          log_ev.push_back({ev_rel, ev_code});
          log_cyc.push_back(gcyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_ev.delete();
    log_cyc.delete();
  endtask

  int n3;

  initial begin : stim
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);

    // Single press: latency and encoding, then release.
    clear_log();
    btn = 16'h0020;
    @(posedge clk); @(negedge clk); chk("lat_k", ev_valid, 0);
    @(posedge clk); @(negedge clk); chk("lat_k1", ev_valid, 0);
    @(posedge clk); @(negedge clk); chk("lat_k2", ev_valid, 1);
    chk("press5_head", {ev_rel, ev_code}, 5'h05);
    tick(4);
    btn = 16'h0000;
    tick(6);
    chk("single_count", log_ev.size(), 2);
    if (log_ev.size() == 2) begin
      chk("single_press", log_ev[0], 5'h05);
      chk("single_rel", log_ev[1], 5'h15);
    end

    // Simultaneous presses: index order on consecutive cycles.
    clear_log();
    btn = 16'h8101;
    tick(8);
    chk("simul_count", log_ev.size(), 3);
    if (log_ev.size() == 3) begin
      chk("simul_0", log_ev[0], 5'h00);
      chk("simul_1", log_ev[1], 5'h08);
      chk("simul_2", log_ev[2], 5'h0F);
      chk("simul_spacing", log_cyc[2] - log_cyc[0], 2);
    end
    btn = 16'h0000;
    tick(8);

    // Back-pressure: four queued, two held pending, nothing lost.
    ev_ready = 1'b0;
    clear_log();
    btn = 16'h003F;
    tick(10);
    chk("bp_ovf", ovf, 0);
    chk("bp_valid", ev_valid, 1);
    chk("bp_no_pop", log_ev.size(), 0);
    ev_ready = 1'b1;
    tick(10);
    chk("bp_count", log_ev.size(), 6);
    for (int i = 0; i < 6 && i < log_ev.size(); i++) chk("bp_order", log_ev[i], 5'(i));
    btn = 16'h0000;
    tick(12);

    // Lost event: key 3 re-pressed while its press is still pending.
    ev_ready = 1'b0;
    clear_log();
    btn = 16'h0017;
    tick(8);
    btn = 16'h001F; tick(1);
    btn = 16'h0017; tick(1);
    btn = 16'h001F; tick(3);
    chk("lost_ovf", ovf, 1);
    ev_ready = 1'b1;
    tick(10);
    chk("lost_count", log_ev.size(), 6);
    n3 = 0;
    foreach (log_ev[i]) if (log_ev[i] == 5'h03) n3++;
    chk("lost_one_press3", n3, 1);
    if (log_ev.size() == 6) begin
      chk("lost_press3_pos", log_ev[4], 5'h03);
      chk("lost_rel3_pos", log_ev[5], 5'h13);
    end
    btn = 16'h0000;
    tick(12);
    chk("ovf_sticky", ovf, 1);

    // Flush with three queued and keys still held.
    ev_ready = 1'b0;
    clear_log();
    btn = 16'h0007;
    tick(8);
    chk("clr_pre_valid", ev_valid, 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_valid", ev_valid, 0);
    chk("clr_ovf", ovf, 0);
    ev_ready = 1'b1;
    tick(8);
    chk("clr_no_reemit", log_ev.size(), 0);

    // Reset mid-operation with key 9 held through it.
    btn = 16'h0200;
    tick(1);
    rst_n = 1'b0;
    tick(3);
    clear_log();
    rst_n = 1'b1;
    tick(10);
    chk("rst_count", log_ev.size(), 1);
    if (log_ev.size() == 1) chk("rst_key9", log_ev[0], 5'h09);

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) btn = btn ^ (16'd1 << $urandom_range(15));
      if ($urandom_range(15) == 0) btn = btn ^ 16'($urandom);
      ev_ready = ($urandom_range(3) != 0);
      clr      = ($urandom_range(49) == 0);
      tick(1);
    end
    clr = 1'b0;
    btn = 16'h0000;
    ev_ready = 1'b1;
    tick(40);
    chk("final_drained", ev_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
